move_recorder: RTL
==================

MOVE_RECORDER -- requirements
Module: move_recorder

Interface
REQ-001 Parameter: TICK_W, default 12, width of the free-running sample-tick counter (one tick every 2^TICK_W clocks).
REQ-002 Parameter: MAX_MOVES, default 20, capacity of the move buffer (2 bits per move, 40-bit buffer).
REQ-003 Port: clk  input  1  single system clock, all state on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: btn  input  5  raw push buttons; btn[0]=UP, btn[1]=DOWN, btn[2]=LEFT, btn[3]=RIGHT, btn[4]=ENTER.
REQ-006 Port: ord  output  40  packed move list; move k in bits [2k+1:2k]; code UP=0, DOWN=1, LEFT=2, RIGHT=3.
REQ-007 Port: cnt  output  40  number of recorded moves, 0..MAX_MOVES, bits [39:5] always zero.
REQ-008 Port: comp  output  1  sequence closed; high from ENTER-close until ENTER-clear.
REQ-009 Port: move_stb  output  1  one-clock pulse when a move is appended.
REQ-010 Port: move_code  output  2  code of the last appended move, held between pulses.
REQ-011 Port: full  output  1  high while cnt == MAX_MOVES.
REQ-012 Port: ovf  output  1  sticky; set when a direction press is dropped because the buffer is full.

Function
REQ-013 btn SHALL pass through a 2-flop synchronizer per bit before any use.
REQ-014 A TICK_W-bit counter SHALL increment every clock and wrap; tick = (counter == 0).
REQ-015 On tick only, synchronized btn SHALL be sampled; a press event for bit i SHALL occur when sampled bit i = 1 and press flag i = 0, which then sets flag i.
REQ-016 Press flag i SHALL clear on a tick where sampled bit i = 0; no second event for bit i until cleared (held button = one event).
REQ-017 Per tick at most one event SHALL be acted on: ENTER highest priority, then btn[0], btn[1], btn[2], btn[3]; flags for all newly pressed bits SHALL still set (lost events not replayed).
REQ-018 Direction event, comp=0, cnt<MAX_MOVES: write code into ord[2*cnt+1:2*cnt], cnt <= cnt+1, move_code <= code, move_stb = 1 on the following clock only.
REQ-019 Direction event, comp=0, cnt==MAX_MOVES: ord/cnt unchanged, no move_stb, ovf <= 1.
REQ-020 Direction event, comp=1: ignored entirely (no state change, no ovf).
REQ-021 ENTER event, comp=0, cnt>0: comp <= 1; ord/cnt frozen.
REQ-022 ENTER event, comp=0, cnt==0: ignored.
REQ-023 ENTER event, comp=1: comp <= 0, cnt <= 0, ord <= 0, ovf <= 0; move_code unchanged.
REQ-024 All updates SHALL take effect on the clock edge of the tick; outputs registered, latency tick-edge -> output = 1 clock (synchronizer adds 2 clocks before sampling).
REQ-025 full SHALL be a registered or combinational decode of cnt consistent in the same cycle as cnt.

Reset
REQ-026 rst=1 SHALL asynchronously force: ord=0, cnt=0, comp=0, move_stb=0, move_code=0, full=0, ovf=0, tick counter=0, synchronizers=0, press flags=0.
REQ-027 rst asserted mid-press SHALL discard the event; a button still held at deassert SHALL produce one event on the first tick where it is sampled high.

Verification
REQ-028 Reset, press UP, DOWN, RIGHT (each held >2 ticks, released >2 ticks) -> cnt=3, ord[5:0]=6'b11_01_00, three move_stb pulses, move_code=3.
REQ-029 Hold LEFT for 10 ticks -> exactly one append, cnt=1, ord[1:0]=2.
REQ-030 21 RIGHT presses -> cnt=20, full=1, ord=40'hFF_FFFF_FFFF, ovf=1 after 21st, 20 move_stb pulses.
REQ-031 Record 2 moves, ENTER -> comp=1; press UP -> cnt stays 2; ENTER -> comp=0, cnt=0, ord=0, ovf=0.
REQ-032 ENTER with cnt=0 -> comp stays 0; UP and RIGHT sampled same tick -> only UP recorded, RIGHT not recorded after UP release while RIGHT still held.
REQ-033 Assert rst asynchronously between ticks with cnt=5, comp=1 -> all outputs zero immediately, before next clk edge.

Source files
------------

// File: rtl/move_recorder.sv
// move_recorder: samples synchronized push buttons on a slow tick and records
// direction presses as a packed 2-bit move list, closed and cleared by ENTER.
module move_recorder #(
    parameter int TICK_W    = 12,
    parameter int MAX_MOVES = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    output logic [39:0] ord,
    output logic [39:0] cnt,
    output logic        comp,
    output logic        move_stb,
    output logic [1:0]  move_code,
    output logic        full,
    output logic        ovf
);
    logic [4:0]        sync1_q, sync2_q, flag_q, flag_d, press;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [39:0]       ord_q, ord_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [1:0]        code_q, code_d, dir_code;
    logic              comp_q, comp_d, stb_q, stb_d, ovf_q, ovf_d;
    logic              tick, enter_ev, dir_ev, is_full;

    assign tick     = tick_q == '0;
    // flags latch the sampled level, so a held button yields a single rising event
    assign press    = tick ? (sync2_q & ~flag_q) : 5'd0;
    assign enter_ev = press[4];
    assign dir_ev   = !enter_ev && (press[3:0] != 4'd0);
    assign dir_code = press[0] ? 2'd0 : press[1] ? 2'd1 : press[2] ? 2'd2 : 2'd3;
    assign is_full  = cnt_q == 5'(MAX_MOVES);

    always_comb begin
        tick_d = tick_q + TICK_W'(1);
        flag_d = tick ? sync2_q : flag_q;
        ord_d  = ord_q;
        cnt_d  = cnt_q;
        comp_d = comp_q;
        ovf_d  = ovf_q;
        code_d = code_q;
        stb_d  = 1'b0;
        if (enter_ev) begin
            if (comp_q) begin
                comp_d = 1'b0;
                cnt_d  = '0;
                ord_d  = '0;
                ovf_d  = 1'b0;
            end else if (cnt_q != '0) begin
                comp_d = 1'b1;
            end
        end else if (dir_ev && !comp_q) begin
            if (is_full) begin
                ovf_d = 1'b1;
            end else begin
                // slots above cnt are always zero, so OR-ing in the new code is enough
                ord_d  = ord_q | (40'(dir_code) << {cnt_q, 1'b0});
                cnt_d  = cnt_q + 5'd1;
                code_d = dir_code;
                stb_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            flag_q  <= '0;
            tick_q  <= '0;
            ord_q   <= '0;
            cnt_q   <= '0;
            comp_q  <= 1'b0;
            ovf_q   <= 1'b0;
            code_q  <= '0;
            stb_q   <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            flag_q  <= flag_d;
            tick_q  <= tick_d;
            ord_q   <= ord_d;
            cnt_q   <= cnt_d;
            comp_q  <= comp_d;
            ovf_q   <= ovf_d;
            code_q  <= code_d;
            stb_q   <= stb_d;
        end
    end

    assign ord       = ord_q;
    assign cnt       = {35'd0, cnt_q};
    assign comp      = comp_q;
    assign move_stb  = stb_q;
    assign move_code = code_q;
    assign full      = is_full;
    assign ovf       = ovf_q;
endmodule
